// File: rtl/data_mem_responder_pkg.sv
// Memory-interface definitions shared across the core: response FSM
// encoding, default data-memory base address and word geometry.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } rsp_state_e;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h0000_2000;
  localparam int unsigned WORD_BYTES     = 4;
  localparam int unsigned WORD_BITS      = WORD_BYTES * 8;
  localparam logic [1:0]  ALIGN_MASK     = 2'b00;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == ALIGN_MASK;
  endfunction

endpackage

// File: rtl/data_mem_responder_word_ram.sv
// Single-port word array: synchronous write, registered read of the
// addressed word every cycle (read-before-write on a same-word store).
module word_ram
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_addr,
  input  logic [WORD_BITS-1:0] i_wdata,
  output logic [WORD_BITS-1:0] o_rdata
);

  logic [WORD_BITS-1:0] r_mem [DEPTH];
  logic [WORD_BITS-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time over valid/ready, response
// strobe LATENCY cycles after the accept edge, with range/alignment check.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] SPAN     = 32'(DEPTH * WORD_BYTES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  rsp_state_e    r_state;
  rsp_state_e    w_next;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic          r_err;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_err;

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_ram_addr;
  logic          w_err;
  logic          w_accept;
  logic          w_ram_we;
  logic [31:0]   w_ram_rdata;
  logic [31:0]   w_rsp_rdata;

  // Offset wraps, so addresses below the base land far out of range.
  assign w_off    = i_req_addr - BASE_ADDR;
  assign w_idx    = w_off[2 +: AW];
  assign w_err    = !is_word_aligned(i_req_addr) || (w_off >= SPAN);
  assign w_accept = i_req_valid && o_req_ready && !i_reset;
  assign w_ram_we = w_accept && i_req_we && !w_err;

  // After the accept the RAM keeps reading the latched word; nothing writes
  // it until the next accept, so its read register doubles as response data.
  assign w_ram_addr = w_accept ? w_idx : r_idx;

  word_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (i_req_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == CW'(1)) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: o_req_ready = 1'b1;
      ST_RESP: o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_we  <= 1'b0;
      r_err <= 1'b0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_cnt <= CNT_LOAD;
      r_we  <= i_req_we;
      r_err <= w_err;
      r_idx <= w_idx;
    end else if (r_state == ST_WAIT) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign w_rsp_rdata = (r_we || r_err) ? 32'h0 : w_ram_rdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else if (r_state == ST_RESP) begin
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= r_err;
    end
  end

  assign o_rsp_rdata = (r_state == ST_RESP) ? w_rsp_rdata : r_rsp_rdata;
  assign o_rsp_err   = (r_state == ST_RESP) ? r_err       : r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 and LATENCY=1 instances driven in
// turn, responses checked by a negedge monitor against a queued model.
module tb_data_mem_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_2000;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];

  wire         rdy0, rdy1, vld0, vld1, err0, err1;
  wire  [31:0] rdata0, rdata1;
  wire  [1:0]  req_ready = {rdy1, rdy0};
  wire  [1:0]  rsp_valid = {vld1, vld0};
  wire  [1:0]  rsp_err   = {err1, err0};
  logic [31:0] rsp_rdata [2];
  assign rsp_rdata[0] = rdata0;
  assign rsp_rdata[1] = rdata1;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) u_dut_l2 (
    .i_clk(clk), .i_reset(reset[0]), .i_req_valid(req_valid[0]), .o_req_ready(rdy0),
    .i_req_we(req_we[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
    .o_rsp_valid(vld0), .o_rsp_rdata(rdata0), .o_rsp_err(err0)
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) u_dut_l1 (
    .i_clk(clk), .i_reset(reset[1]), .i_req_valid(req_valid[1]), .o_req_ready(rdy1),
    .i_req_we(req_we[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
    .o_rsp_valid(vld1), .o_rsp_rdata(rdata1), .o_rsp_err(err1)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mem_m [2][DEPTH];

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic model_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 != 0) || (off >= 32'(DEPTH * 4));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   qs;
    qs = (d == 0) ? q0.size() : q1.size();
    if (qs == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL dut%0d rsp_unexpected: got rsp_valid=1 at cycle %0d expected no response", d, cyc);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("dut%0d rsp_cycle", d), cyc, e.cyc);
    chk($sformatf("dut%0d rsp_rdata", d), rsp_rdata[d], e.data);
    chk($sformatf("dut%0d rsp_err", d), 32'(rsp_err[d]), 32'(e.err));
  endtask

  always @(negedge clk) begin
    if (rsp_valid[0] === 1'b1) mon(0);
    if (rsp_valid[1] === 1'b1) mon(1);
  end

  // Model the effect of an accept at the current cycle and queue the response.
  task automatic model_accept(input int d, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit expect_rsp);
    exp_t e;
    logic err;
    int   idx;
    err   = model_err(addr);
    idx   = int'((addr - BASE) / 4);
    e.cyc = cyc + lat(d);
    e.err = err;
    if (we) begin
      e.data = 32'h0;
      if (!err) mem_m[d][idx] = wdata;
    end else begin
      e.data = err ? 32'h0 : mem_m[d][idx];
    end
    if (expect_rsp) push_exp(d, e);
  endtask

  task automatic present(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output bit ok);
    int waitc;
    @(negedge clk);
    chk($sformatf("dut%0d ready_idle", d), 32'(req_ready[d]), 32'h1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    waitc = 0;
    while (req_ready[d] !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    ok = (req_ready[d] === 1'b1);
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL dut%0d ready_timeout: got req_ready=0 for 50 cycles expected 1", d);
      req_valid[d] = 1'b0;
    end
  endtask

  task automatic issue(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit holdoff);
    bit ok;
    present(d, we, addr, wdata, ok);
    if (!ok) return;
    model_accept(d, we, addr, wdata, 1'b1);
    for (int k = 1; k <= lat(d); k++) begin
      @(negedge clk);
      chk($sformatf("dut%0d ready_busy", d), 32'(req_ready[d]), 32'h0);
      if (holdoff && k < lat(d)) begin
        req_we[d]    = 1'($urandom_range(0, 1));
        req_addr[d]  = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        req_wdata[d] = $urandom;
      end else begin
        req_valid[d] = 1'b0;
      end
      if (!holdoff) req_valid[d] = 1'b0;
    end
  endtask

  task automatic issue_then_reset(input int d, input logic [31:0] addr, input logic [31:0] wdata);
    bit ok;
    present(d, 1'b1, addr, wdata, ok);
    if (!ok) return;
    model_accept(d, 1'b1, addr, wdata, lat(d) == 1);
    @(negedge clk);
    req_valid[d] = 1'b0;
    reset[d]     = 1'b1;
    @(negedge clk);
    reset[d] = 1'b0;
    chk($sformatf("dut%0d post_reset_ready", d), 32'(req_ready[d]), 32'h1);
    chk($sformatf("dut%0d post_reset_valid", d), 32'(rsp_valid[d]), 32'h0);
    chk($sformatf("dut%0d post_reset_rdata", d), rsp_rdata[d], 32'h0);
    chk($sformatf("dut%0d post_reset_err", d), 32'(rsp_err[d]), 32'h0);
  endtask

  task automatic reset_with_valid(input int d, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    reset[d]     = 1'b1;
    req_valid[d] = 1'b1;
    req_we[d]    = 1'b1;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    @(negedge clk);
    reset[d]     = 1'b0;
    req_valid[d] = 1'b0;
    chk($sformatf("dut%0d rst_valid_ready", d), 32'(req_ready[d]), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish by cycle %0d expected finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] a;
    int          sel;
    reset     = 2'b11;
    req_valid = 2'b00;
    req_we    = 2'b00;
    for (int d = 0; d < 2; d++) begin
      req_addr[d]  = 32'h0;
      req_wdata[d] = 32'h0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d reset_ready", d), 32'(req_ready[d]), 32'h1);
      chk($sformatf("dut%0d reset_valid", d), 32'(rsp_valid[d]), 32'h0);
      chk($sformatf("dut%0d reset_rdata", d), rsp_rdata[d], 32'h0);
      chk($sformatf("dut%0d reset_err", d), 32'(rsp_err[d]), 32'h0);
    end
    reset = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        chk($sformatf("dut%0d idle_valid", d), 32'(rsp_valid[d]), 32'h0);
    end

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DEPTH; i++)
        issue(d, 1'b1, BASE + 32'(4 * i), $urandom, 1'b0);

      issue(d, 1'b1, 32'h2004, 32'hDEAD_BEEF, 1'b0);
      issue(d, 1'b0, 32'h2004, 32'h0, 1'b0);
      issue(d, 1'b0, 32'h2006, 32'h0, 1'b0);
      issue(d, 1'b1, 32'h2100, 32'hCAFE_F00D, 1'b0);
      issue(d, 1'b0, 32'h2000, 32'h0, 1'b0);
      issue(d, 1'b0, 32'h1FFC, 32'h0, 1'b0);
      issue(d, 1'b1, 32'h20FC, 32'h1234_5678, 1'b0);
      issue(d, 1'b0, 32'h20FC, 32'h0, 1'b0);
      issue(d, 1'b0, 32'h2004, 32'h0, 1'b1);
      issue(d, 1'b1, 32'h2010, 32'h0BAD_C0DE, 1'b1);
      issue(d, 1'b0, 32'h2010, 32'h0, 1'b0);

      issue_then_reset(d, 32'h2008, 32'hA5A5_A5A5);
      issue(d, 1'b0, 32'h2008, 32'h0, 1'b0);
      reset_with_valid(d, 32'h200C, 32'hFFFF_0000);
      issue(d, 1'b0, 32'h200C, 32'h0, 1'b0);

      for (int i = 0; i < 80; i++) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 7)       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        else if (sel == 7) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        else if (sel == 8) a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 15));
        else               a = $urandom;
        issue(d, 1'($urandom_range(0, 1)), a, $urandom, bit'($urandom_range(0, 1)));
      end
    end

    repeat (5) @(negedge clk);
    chk("dut0 queue_drained", 32'(q0.size()), 32'h0);
    chk("dut1 queue_drained", 32'(q1.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
